// File: rtl/pdetect_pkg.sv
// pdetect_pkg: shared pattern slicing helper and counter saturation constant
package pdetect_pkg;
  localparam int MAX_W = 256;
  function automatic logic [63:0] pat_slice(input logic [MAX_W-1:0] v, input int k, input int i,
                                            input int plen, input int dw);
    return 64'(v >> ((k * plen + plen - 1 - i) * dw)) & ((64'd1 << dw) - 64'd1);
  endfunction
  function automatic logic [63:0] count_max(input int w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/pdetect_window.sv
// pdetect_window: sliding window of accepted symbols with saturating fill count
module pdetect_window #(
  parameter int DATA_W  = 8,
  parameter int PAT_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      shift,
  input  logic [DATA_W-1:0]         data,
  output logic [PAT_LEN*DATA_W-1:0] candidate,
  output logic                      full
);
  localparam int FW = $clog2(PAT_LEN);
  localparam int HW = (PAT_LEN - 1) * DATA_W;
  logic [HW-1:0] win;
  logic [FW-1:0] fill;
  assign candidate = {win, data};
  assign full = fill == FW'(PAT_LEN - 1);
  // shift accepted symbols in; flush discards any partial pattern
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      win  <= '0;
      fill <= '0;
    end else if (shift) begin
      win  <= candidate[HW-1:0];
      fill <= full ? fill : fill + 1'b1;
    end
  end
endmodule

// File: rtl/pdetect_multi.sv
// pdetect_multi: masked multi-pattern detector with registered pulse and saturating count
module pdetect_multi
  import pdetect_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PAT_LEN = 4,
  parameter int NUM_PAT = 2,
  parameter logic [NUM_PAT*PAT_LEN*DATA_W-1:0] PATTERNS = 64'h0A0A0A0A_0A0B0C0D,
  parameter logic [NUM_PAT*PAT_LEN*DATA_W-1:0] MASKS = '1,
  parameter int OVERLAP = 1,
  parameter int COUNT_W = 16,
  localparam int ID_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic [DATA_W-1:0]  i_data,
  input  logic               i_clear_count,
  output logic               o_detected,
  output logic [ID_W-1:0]    o_match_id,
  output logic [NUM_PAT-1:0] o_match_vec,
  output logic [COUNT_W-1:0] o_count
);
  localparam int PW = PAT_LEN * DATA_W;
  localparam logic [COUNT_W-1:0] CMAX = COUNT_W'(count_max(COUNT_W));
  logic [PW-1:0] cand;
  logic full, hit;
  logic [NUM_PAT-1:0] vec_c;
  logic [ID_W-1:0] enc;
  assign hit = i_enable && i_valid && |vec_c;
  pdetect_window #(.DATA_W(DATA_W), .PAT_LEN(PAT_LEN)) u_win (
    .clk(i_clk), .rst(i_rst), .flush(!i_enable || (hit && OVERLAP == 0)),
    .shift(i_enable && i_valid), .data(i_data), .candidate(cand), .full(full)
  );
  for (genvar k = 0; k < NUM_PAT; k++) begin : g_cmp
    assign vec_c[k] = full && (((cand ^ PATTERNS[k*PW +: PW]) & MASKS[k*PW +: PW]) == '0);
  end
  // lowest-index matching pattern wins
  always_comb begin
    enc = '0;
    for (int k = NUM_PAT - 1; k >= 0; k--) enc = vec_c[k] ? ID_W'(k) : enc;
  end
  // registered detect outputs and saturating match counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_detected  <= 1'b0;
      o_match_id  <= '0;
      o_match_vec <= '0;
      o_count     <= '0;
    end else begin
      o_detected  <= hit;
      o_match_vec <= hit ? vec_c : '0;
      o_match_id  <= hit ? enc : o_match_id;
      o_count     <= i_clear_count ? COUNT_W'(hit) : (hit && o_count != CMAX) ? o_count + 1'b1 : o_count;
    end
  end
endmodule

// File: tb/tb_pdetect_multi.sv
// tb_pdetect_multi: three detector configurations against a symbol-history reference model
module tb_pdetect_multi;
  import pdetect_pkg::*;
  localparam logic [63:0] PAT [3] = '{64'h0A0A0A0A_0A0B0C0D, 64'h0A0A0A0A_0A0B0C0D, 64'h0A0A0A0A_00000000};
  localparam logic [63:0] MSK [3] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFF00, 64'hFFFFFFFF_FFFFFFFF};
  localparam int OVL [3] = '{1, 0, 1};
  localparam int CW [3] = '{16, 2, 16};
  logic clk = 0, rst = 1, en = 0, valid = 0, clr = 0;
  logic [7:0] data = 0;
  logic a_det, b_det, c_det;
  logic [0:0] a_id, b_id, c_id;
  logic [1:0] a_vec, b_vec, c_vec;
  logic [15:0] a_cnt, c_cnt;
  logic [1:0] b_cnt;
  logic act_det [3];
  logic [0:0] act_id [3];
  logic [1:0] act_vec [3];
  logic [15:0] act_cnt [3];
  logic [7:0] mh [3][4];
  int mf [3];
  logic mdet [3];
  logic [0:0] mid [3];
  logic [1:0] mvec [3];
  logic [63:0] mcnt [3];
  int errors = 0, checks = 0;
  bit go = 0;
  always #5 clk = ~clk;
  pdetect_multi #(.OVERLAP(1), .COUNT_W(16), .PATTERNS(PAT[0]), .MASKS(MSK[0])) dut_a (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_valid(valid), .i_data(data), .i_clear_count(clr),
    .o_detected(a_det), .o_match_id(a_id), .o_match_vec(a_vec), .o_count(a_cnt));
  pdetect_multi #(.OVERLAP(0), .COUNT_W(2), .PATTERNS(PAT[1]), .MASKS(MSK[1])) dut_b (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_valid(valid), .i_data(data), .i_clear_count(clr),
    .o_detected(b_det), .o_match_id(b_id), .o_match_vec(b_vec), .o_count(b_cnt));
  pdetect_multi #(.OVERLAP(1), .COUNT_W(16), .PATTERNS(PAT[2]), .MASKS(MSK[2])) dut_c (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_valid(valid), .i_data(data), .i_clear_count(clr),
    .o_detected(c_det), .o_match_id(c_id), .o_match_vec(c_vec), .o_count(c_cnt));
  assign act_det[0] = a_det;
  assign act_det[1] = b_det;
  assign act_det[2] = c_det;
  assign act_id[0] = a_id;
  assign act_id[1] = b_id;
  assign act_id[2] = c_id;
  assign act_vec[0] = a_vec;
  assign act_vec[1] = b_vec;
  assign act_vec[2] = c_vec;
  assign act_cnt[0] = a_cnt;
  assign act_cnt[1] = {14'd0, b_cnt};
  assign act_cnt[2] = c_cnt;
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  // reference: remember accepted symbols since the last flush, test the newest four against each pattern
  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      automatic logic [7:0] nh [4];
      automatic int f = mf[n];
      automatic logic [1:0] v = '0;
      automatic logic d = 0;
      automatic logic [0:0] idv = mid[n];
      automatic logic [63:0] c = mcnt[n];
      automatic bit ok;
      for (int i = 0; i < 4; i++) nh[i] = mh[n][i];
      if (rst) begin
        f = 0;
        c = 0;
        idv = 0;
      end else begin
        if (!en) f = 0;
        else if (valid) begin
          for (int i = 0; i < 3; i++) nh[i] = nh[i+1];
          nh[3] = data;
          f = (f < 4) ? f + 1 : 4;
          if (f == 4)
            for (int k = 0; k < 2; k++) begin
              ok = 1;
              for (int i = 0; i < 4; i++)
                if (((64'(nh[i]) ^ pat_slice(MAX_W'(PAT[n]), k, i, 4, 8)) & pat_slice(MAX_W'(MSK[n]), k, i, 4, 8)) != 0) ok = 0;
              v[k] = ok;
            end
          d = |v;
          if (d) begin
            idv = v[0] ? 1'b0 : 1'b1;
            if (OVL[n] == 0) f = 0;
          end
        end
        if (clr) c = 64'(d);
        else if (d && c != count_max(CW[n])) c = c + 1;
      end
      for (int i = 0; i < 4; i++) mh[n][i] <= nh[i];
      mf[n] <= f;
      mdet[n] <= d;
      mvec[n] <= v;
      mid[n] <= idv;
      mcnt[n] <= c;
    end
  end
  // every cycle after the first reset, all outputs of all instances must follow the model
  always @(negedge clk) begin
    if (go)
      for (int n = 0; n < 3; n++) begin
        chk($sformatf("det%0d", n), longint'(act_det[n]), longint'(mdet[n]));
        chk($sformatf("vec%0d", n), longint'(act_vec[n]), longint'(mvec[n]));
        chk($sformatf("id%0d", n), longint'(act_id[n]), longint'(mid[n]));
        chk($sformatf("cnt%0d", n), longint'(act_cnt[n]), longint'(mcnt[n]));
      end
  end
  task automatic step(input logic e, input logic v, input logic [7:0] d, input logic c);
    en = e;
    valid = v;
    data = d;
    clr = c;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    step(0, 0, 8'h00, 0);
    rst = 0;
  endtask
  task automatic sym(input logic [7:0] d);
    step(1, 1, d, 0);
  endtask
  initial begin
    do_reset();
    go = 1;
    chk("reset_det", longint'(a_det), 0);
    chk("reset_cnt", longint'(a_cnt), 0);
    for (int i = 0; i < 10; i++) step(1, 0, 8'h00, 0);
    sym(8'h0A); sym(8'h0B); sym(8'h0C); sym(8'h0D);
    chk("t1_det", longint'(a_det), 1);
    chk("t1_id", longint'(a_id), 0);
    chk("t1_vec", longint'(a_vec), 1);
    chk("t1_b_det", longint'(b_det), 1);
    step(1, 0, 8'h00, 0);
    chk("t1_det_off", longint'(a_det), 0);
    chk("t1_cnt", longint'(a_cnt), 1);
    do_reset();
    for (int i = 0; i < 5; i++) sym(8'h0A);
    chk("t2_id", longint'(a_id), 1);
    chk("t2_cnt_ovl", longint'(a_cnt), 2);
    chk("t2_cnt_noovl", longint'(b_cnt), 1);
    do_reset();
    sym(8'h0A); sym(8'h0B);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0);
    sym(8'h0C); sym(8'h0D);
    chk("t3_gap_det", longint'(a_det), 1);
    do_reset();
    sym(8'h0A); sym(8'h0B);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0);
    sym(8'h0C); sym(8'h0D);
    chk("t3_dis_det", longint'(a_det), 0);
    chk("t3_dis_cnt", longint'(a_cnt), 0);
    do_reset();
    sym(8'h0A); sym(8'h0B); sym(8'h0C); sym(8'h77);
    chk("t4_mask_det", longint'(b_det), 1);
    chk("t4_mask_id", longint'(b_id), 0);
    chk("t4_nomask_det", longint'(a_det), 0);
    do_reset();
    sym(8'h00); sym(8'h00); sym(8'h00);
    chk("t4_zero3", longint'(c_det), 0);
    sym(8'h00);
    chk("t4_zero4", longint'(c_det), 1);
    do_reset();
    for (int i = 0; i < 20; i++) sym(8'h0A);
    chk("t5_sat", longint'(b_cnt), 3);
    sym(8'h0A); sym(8'h0A); sym(8'h0A);
    step(1, 1, 8'h0A, 1);
    chk("t5_clr_match", longint'(b_cnt), 1);
    step(1, 0, 8'h00, 1);
    chk("t5_clr", longint'(b_cnt), 0);
    do_reset();
    sym(8'h0A); sym(8'h0B); sym(8'h0C);
    do_reset();
    sym(8'h0D);
    chk("t6_after_rst", longint'(a_det), 0);
    sym(8'h0A); sym(8'h0B); sym(8'h0C); sym(8'h0D);
    chk("t6_redetect", longint'(a_det), 1);
    for (int i = 0; i < 3000; i++) begin
      automatic logic [7:0] d;
      case ($urandom_range(0, 7))
        0, 6: d = 8'h0A;
        1: d = 8'h0B;
        2: d = 8'h0C;
        3: d = 8'h0D;
        4: d = 8'h00;
        5: d = 8'h77;
        default: d = 8'($urandom);
      endcase
      rst = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, d, $urandom_range(0, 49) == 0);
    end
    rst = 0;
    step(1, 0, 8'h00, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
